// File: rtl/conv1_mac_sequencer_if.sv
// Tap stream, result stream and external multiplier hookup for one conv1 lane.
// "slave" is the sequencer side; "master" is the feeding/consuming environment.
interface conv1_mac_sequencer_if;
    logic               tap_valid;
    logic               tap_ready;
    logic signed [13:0] tap_a;
    logic signed [6:0]  tap_w;
    logic signed [13:0] mul_din0;
    logic signed [6:0]  mul_din1;
    logic signed [20:0] mul_dout;
    logic               out_valid;
    logic               out_ready;
    logic signed [13:0] out_data;

    modport master (
        output tap_valid, tap_a, tap_w, out_ready, mul_dout,
        input  tap_ready, out_valid, out_data, mul_din0, mul_din1
    );

    modport slave (
        input  tap_valid, tap_a, tap_w, out_ready, mul_dout,
        output tap_ready, out_valid, out_data, mul_din0, mul_din1
    );
endinterface

// File: rtl/conv1_mac_sequencer.sv
// One conv1 output-channel lane: streams TAPS products through a shared external
// multiplier, accumulates onto a rounded bias, then shifts, ReLUs and saturates.
module conv1_mac_sequencer #(
    parameter int unsigned TAPS      = 25,
    parameter int unsigned ACC_WIDTH = 26,
    parameter int unsigned SHIFT     = 6,
    parameter bit          RELU      = 1'b1
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               ap_start,
    output logic               ap_idle,
    output logic               ap_ready,
    output logic               ap_done,
    input  logic signed [13:0] bias,
    conv1_mac_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(TAPS);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(8191);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-8192);
    localparam logic signed [ACC_WIDTH-1:0] ROUND   = ACC_WIDTH'(1) << (SHIFT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [CNT_W-1:0]            r_cnt;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [20:0]          r_prod;
    logic                        r_prod_vld;
    logic signed [13:0]          r_out_data;
    logic                        r_out_valid;

    logic                        w_fire;
    logic                        w_last;
    logic signed [ACC_WIDTH-1:0] w_bias_ext;
    logic signed [ACC_WIDTH-1:0] w_acc_init;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] w_final;
    logic signed [ACC_WIDTH-1:0] w_shift;
    logic signed [ACC_WIDTH-1:0] w_relu;
    logic signed [13:0]          w_sat;

    assign w_fire     = (r_state == S_RUN) && bus.tap_valid;
    assign w_last     = (r_cnt == CNT_W'(TAPS - 1));
    assign w_bias_ext = {{(ACC_WIDTH-14){bias[13]}}, bias};
    assign w_acc_init = (w_bias_ext <<< SHIFT) + ROUND;
    assign w_prod_ext = {{(ACC_WIDTH-21){r_prod[20]}}, r_prod};

    // The last product is still in r_prod when DRAIN starts, so fold it in here.
    assign w_final = r_acc + w_prod_ext;
    assign w_shift = w_final >>> SHIFT;
    assign w_relu  = (RELU && w_shift[ACC_WIDTH-1]) ? '0 : w_shift;

    always_comb begin
        w_sat = w_relu[13:0];
        if (w_relu > SAT_MAX)      w_sat = 14'h1FFF;
        else if (w_relu < SAT_MIN) w_sat = 14'h2000;
    end

    assign bus.mul_din0  = w_fire ? bus.tap_a : '0;
    assign bus.mul_din1  = w_fire ? bus.tap_w : '0;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        ap_idle       = 1'b0;
        ap_ready      = 1'b0;
        ap_done       = 1'b0;
        bus.tap_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) w_next = S_RUN;
            end
            S_RUN: begin
                bus.tap_ready = 1'b1;
                if (w_fire && w_last) begin
                    ap_ready = 1'b1;
                    w_next   = S_DRAIN;
                end
            end
            S_DRAIN: w_next = S_OUT;
            S_OUT: begin
                if (bus.out_ready) begin
                    ap_done = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_prod      <= '0;
            r_prod_vld  <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_prod_vld <= 1'b0;
                    if (ap_start) begin
                        r_acc <= w_acc_init;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    // One-cycle product pipeline: a bubble leaves r_prod_vld low and adds nothing.
                    if (r_prod_vld) r_acc <= r_acc + w_prod_ext;
                    r_prod_vld <= w_fire;
                    if (w_fire) begin
                        r_prod <= bus.mul_dout;
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    r_prod_vld  <= 1'b0;
                    r_out_data  <= w_sat;
                    r_out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (bus.out_ready) r_out_valid <= 1'b0;
                end
                default: r_prod_vld <= 1'b0;
            endcase
        end
    end
endmodule
